serial_add_sched: RTL and testbench

Bit-serial add scheduler that time-shares a single 1-bit full-adder cell between two requesters. Each accepted request streams its WIDTH-bit operands LSB-first through the cell over WIDTH cycles, with the carry held in a flop between bits. The block returns the sum, carry-out and the id of the requester served. It sits between client datapaths and the shared full-adder cell, providing arbitration, sequencing and result buffering.

---
 rtl/serial_add_sched_if.sv | 47 ++++
 rtl/serial_add_sched.sv | 124 ++++++++++++
 tb/tb_serial_add_sched.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/serial_add_sched_if.sv
// Request/result bundle for the bit-serial add scheduler.
// Sub-select lines exist only when SERIAL_ADD_SUB_EN is defined.
interface serial_add_sched_if #(
  parameter int WIDTH = 8
);
  logic             req0;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic             cin0;
  logic             req1;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic             cin1;
`ifdef SERIAL_ADD_SUB_EN
  logic             sub0;
  logic             sub1;
`endif
  logic             gnt0;
  logic             gnt1;
  logic             busy;
  logic             res_valid;
  logic             res_id;
  logic [WIDTH-1:0] res_sum;
  logic             res_cout;

  modport master (
`ifdef SERIAL_ADD_SUB_EN
    output sub0, sub1,
`endif
    output req0, a0, b0, cin0,
    output req1, a1, b1, cin1,
    input  gnt0, gnt1, busy,
    input  res_valid, res_id,
    input  res_sum, res_cout
  );

  modport slave (
`ifdef SERIAL_ADD_SUB_EN
    input  sub0, sub1,
`endif
    input  req0, a0, b0, cin0,
    input  req1, a1, b1, cin1,
    output gnt0, gnt1, busy,
    output res_valid, res_id,
    output res_sum, res_cout
  );
endinterface

// File: rtl/serial_add_sched.sv
// Round-robin bit-serial adder sharing one full-adder cell.
// Define SERIAL_ADD_SUB_EN to add per-requester subtract.
module serial_add_sched #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  serial_add_sched_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] opa_q;
  logic [WIDTH-1:0] opb_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] sum_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic             id_q;
  logic             ptr_q;
  logic             gnt0_q;
  logic             gnt1_q;
  logic             valid_q;
  logic             rid_q;
  logic             cout_q;

  logic             fa_s;
  logic             fa_c;
  logic [WIDTH-1:0] acc_d;
  logic             pick1;
  logic [WIDTH-1:0] opa_d;
  logic [WIDTH-1:0] opb_d;
  logic             carry_d;

  always_comb begin
    fa_s = opa_q[0] ^ opb_q[0] ^ carry_q;
    fa_c = (opa_q[0] & opb_q[0])
         | (carry_q & (opa_q[0] ^ opb_q[0]));
    acc_d = acc_q >> 1;
    acc_d[WIDTH-1] = fa_s;
  end

  // Ties go to whichever side was not served last.
  always_comb begin
    pick1   = bus.req1 & (~bus.req0 | ~ptr_q);
    opa_d   = pick1 ? bus.a1 : bus.a0;
    opb_d   = pick1 ? bus.b1 : bus.b0;
    carry_d = pick1 ? bus.cin1 : bus.cin0;
`ifdef SERIAL_ADD_SUB_EN
    if (pick1 ? bus.sub1 : bus.sub0) begin
      opb_d   = ~opb_d;
      carry_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      id_q    <= 1'b0;
      ptr_q   <= 1'b1;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      valid_q <= 1'b0;
      rid_q   <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.req0 | bus.req1) begin
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            carry_q <= carry_d;
            id_q    <= pick1;
            ptr_q   <= pick1;
            cnt_q   <= '0;
            gnt0_q  <= ~pick1;
            gnt1_q  <= pick1;
            state_q <= RUN;
          end
        end
        RUN: begin
          opa_q   <= opa_q >> 1;
          opb_q   <= opb_q >> 1;
          carry_q <= fa_c;
          acc_q   <= acc_d;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_q <= DONE;
            sum_q   <= acc_d;
            cout_q  <= fa_c;
            rid_q   <= id_q;
            valid_q <= 1'b1;
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.gnt0      = gnt0_q;
  assign bus.gnt1      = gnt1_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.res_valid = valid_q;
  assign bus.res_id    = rid_q;
  assign bus.res_sum   = sum_q;
  assign bus.res_cout  = cout_q;
endmodule

// File: tb/tb_serial_add_sched.sv
// Bench for serial_add_sched: transaction-level model
// plus directed vectors with literal expectations.
module tb_serial_add_sched;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   chk_en = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  serial_add_sched_if #(.WIDTH(W)) bus ();

  serial_add_sched #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Model: an op occupies WIDTH+2 cycles from its sampling edge.
  int           ph;
  bit           ptr;
  logic         m_g0, m_g1, m_val, m_id, m_cout;
  logic [W-1:0] m_sum;
  logic [W:0]   pend;
  logic         pid;

  function automatic logic [W:0] op_result(
    input logic [W-1:0] a, input logic [W-1:0] b,
    input logic cin, input logic sub);
    logic [W-1:0] nb;
    if (sub) begin
      nb = ~b;
      return {1'b0, a} + {1'b0, nb} + (W+1)'(1);
    end
    return {1'b0, a} + {1'b0, b} + (W+1)'(cin);
  endfunction

  always @(posedge clk) begin
    logic s0, s1;
    s0 = 1'b0;
    s1 = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    s0 = bus.sub0;
    s1 = bus.sub1;
`endif
    if (rst) begin
      ph = 0; ptr = 1'b1;
      m_g0 = 0; m_g1 = 0; m_val = 0;
      m_id = 0; m_cout = 0; m_sum = '0;
    end else begin
      m_g0 = 0; m_g1 = 0; m_val = 0;
      if (ph == 0) begin
        if (bus.req0 || bus.req1) begin
          pid = (bus.req0 && bus.req1) ? ~ptr : bus.req1;
          ptr = pid;
          pend = pid ? op_result(bus.a1, bus.b1, bus.cin1, s1)
                     : op_result(bus.a0, bus.b0, bus.cin0, s0);
          m_g0 = ~pid;
          m_g1 = pid;
          ph = 1;
        end
      end else if (ph == W + 1) begin
        ph = 0;
      end else begin
        if (ph == W) begin
          m_val = 1; m_id = pid;
          m_sum = pend[W-1:0]; m_cout = pend[W];
        end
        ph++;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      n_cmp++;
      if ({bus.gnt0, bus.gnt1, bus.busy, bus.res_valid,
           bus.res_id, bus.res_cout, bus.res_sum} !==
          {m_g0, m_g1, (ph != 0), m_val,
           m_id, m_cout, m_sum}) begin
        n_bad++;
        $display("FAIL cycle t=%0t dut g=%b%b bsy=%b v=%b id=%b c=%b s=%h model g=%b%b bsy=%b v=%b id=%b c=%b s=%h",
          $time, bus.gnt0, bus.gnt1, bus.busy, bus.res_valid,
          bus.res_id, bus.res_cout, bus.res_sum,
          m_g0, m_g1, (ph != 0), m_val, m_id, m_cout, m_sum);
      end
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic run_op(
    input bit id, input logic [W-1:0] a, input logic [W-1:0] b,
    input logic cin, input logic sub,
    output int gcyc, output int vcyc,
    output logic [W-1:0] s, output logic c, output logic rid);
    @(negedge clk);
    if (id) begin
      bus.a1 = a; bus.b1 = b; bus.cin1 = cin; bus.req1 = 1;
    end else begin
      bus.a0 = a; bus.b0 = b; bus.cin0 = cin; bus.req0 = 1;
    end
`ifdef SERIAL_ADD_SUB_EN
    if (id) bus.sub1 = sub; else bus.sub0 = sub;
`else
    if (sub) $display("note: sub ignored in add-only build");
`endif
    gcyc = -1; vcyc = -1; s = 'x; c = 1'bx; rid = 1'bx;
    for (int k = 1; k <= 40 && vcyc < 0; k++) begin
      @(negedge clk);
      if (gcyc < 0 && (id ? bus.gnt1 : bus.gnt0)) begin
        gcyc = k;
        if (id) bus.req1 = 0; else bus.req0 = 0;
      end
      if (bus.res_valid) begin
        vcyc = k; s = bus.res_sum;
        c = bus.res_cout; rid = bus.res_id;
      end
    end
    if (vcyc < 0) begin
      n_cmp++; n_bad++;
      $display("FAIL op_timeout id=%0d got=none exp=res_valid", id);
      bus.req0 = 0; bus.req1 = 0;
    end
  endtask

  task automatic op_lit(
    input string nm, input bit id,
    input logic [W-1:0] a, input logic [W-1:0] b,
    input logic cin, input logic sub,
    input logic [W-1:0] es, input logic ec);
    int g, v;
    logic [W-1:0] s;
    logic c, r;
    run_op(id, a, b, cin, sub, g, v, s, c, r);
    chk({nm, "_gcyc"}, g, 1);
    chk({nm, "_vcyc"}, v, W + 1);
    chk({nm, "_sum"}, 32'(s), 32'(es));
    chk({nm, "_cout"}, 32'(c), 32'(ec));
    chk({nm, "_id"}, 32'(r), 32'(id));
  endtask

  initial begin
    int gk[$], vk[$];
    bit gid[$], vid[$];
    logic [W-1:0] vs[$];
    logic vc[$];
    bit seen_v;

    bus.req0 = 1; bus.a0 = 8'h12; bus.b0 = 8'h34; bus.cin0 = 0;
    bus.req1 = 1; bus.a1 = 8'hF0; bus.b1 = 8'h0F; bus.cin1 = 1;
`ifdef SERIAL_ADD_SUB_EN
    bus.sub0 = 0; bus.sub1 = 0;
`endif
    @(posedge clk);
    chk_en = 1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_outs", {bus.gnt0, bus.gnt1, bus.busy, bus.res_valid,
                     bus.res_id, bus.res_cout, bus.res_sum}, 0);
    rst = 0;

    // Both requesters held from reset.
    for (int k = 1; k <= 60 && vk.size() < 4; k++) begin
      @(negedge clk);
      if (bus.gnt0) begin gk.push_back(k); gid.push_back(0); end
      if (bus.gnt1) begin gk.push_back(k); gid.push_back(1); end
      if (bus.res_valid) begin
        vk.push_back(k); vid.push_back(bus.res_id);
        vs.push_back(bus.res_sum); vc.push_back(bus.res_cout);
        if (vk.size() == 4) begin bus.req0 = 0; bus.req1 = 0; end
      end
    end
    chk("rr_ngrants", gk.size(), 4);
    chk("rr_nvalid", vk.size(), 4);
    if (gk.size() == 4 && vk.size() == 4) begin
      chk("rr_first_gnt", gk[0], 1);
      chk("rr_order", {gid[0], gid[1], gid[2], gid[3]}, 4'b0101);
      chk("rr_ids", {vid[0], vid[1], vid[2], vid[3]}, 4'b0101);
      chk("rr_space1", vk[1] - vk[0], 10);
      chk("rr_space3", vk[3] - vk[2], 10);
      chk("rr_sum0", 32'(vs[0]), 32'h46);
      chk("rr_sum1", {vc[1], vs[1]}, 9'h100);
    end
    bus.req0 = 0; bus.req1 = 0;
    repeat (3) @(negedge clk);

    op_lit("add5a3c", 0, 8'h5A, 8'h3C, 0, 0, 8'h96, 0);
    op_lit("ff01",    1, 8'hFF, 8'h01, 0, 0, 8'h00, 1);
    op_lit("ff00c",   1, 8'hFF, 8'h00, 1, 0, 8'h00, 1);
    op_lit("a5a5c",   0, 8'hA5, 8'hA5, 1, 0, 8'h4B, 1);

    // Reset during the 4th RUN cycle.
    @(negedge clk);
    bus.a0 = 8'h77; bus.b0 = 8'h11; bus.cin0 = 0; bus.req0 = 1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (bus.gnt0) bus.req0 = 0;
    end
    chk("mid_busy_pre", bus.busy, 1);
    rst = 1;
    @(negedge clk);
    chk("mid_busy_post", bus.busy, 0);
    rst = 0;
    seen_v = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.res_valid) seen_v = 1;
    end
    chk("mid_no_valid", seen_v, 0);
    op_lit("post_rst", 0, 8'h01, 8'h01, 0, 0, 8'h02, 0);

`ifdef SERIAL_ADD_SUB_EN
    op_lit("sub_lt", 0, 8'h10, 8'h20, 0, 1, 8'hF0, 0);
    op_lit("sub_ge", 0, 8'h20, 8'h10, 1, 1, 8'h10, 1);
    op_lit("sub_eq", 1, 8'h33, 8'h33, 0, 1, 8'h00, 1);
`endif

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
